// File: rtl/tx_buffer.sv
// Transmit buffer: byte FIFO feeding an 8N1 LSB-first serialiser.
// Bit timing is a clock-enable style divider of master_clk; the whole block is single-domain.
module tx_buffer #(
    parameter int CLK_DIV = 83333,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              master_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              tx_serial,
    output logic              tx_busy
);

    localparam logic [16:0]   BAUD_LAST = 17'(CLK_DIV - 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [16:0]         r_baud_cnt;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_idx;
    logic                r_overflow;
    logic                r_tx_serial;
    logic                r_tx_busy;
    logic                w_push;
    logic                w_pop;
    logic                w_bit_end;

    // Full/empty come from the registered count, so a slot freed by this cycle's pop
    // only becomes writable next cycle, and a same-cycle push cannot trigger a pop.
    assign fifo_full  = (r_count == FULL_CNT);
    assign fifo_empty = (r_count == '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign tx_serial  = r_tx_serial;
    assign tx_busy    = r_tx_busy;
    assign w_push     = wr_en && !fifo_full;
    assign w_bit_end  = (r_baud_cnt == BAUD_LAST);

    always_ff @(posedge master_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: if (w_bit_end) w_state_next = S_DATA;
            S_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
            S_STOP:  if (w_bit_end) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge master_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && fifo_full;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered RAM read doubles as the shift-register load.
    always_ff @(posedge master_clk) begin
        if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
        end else if ((r_state == S_DATA) && w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
        end else begin
            if ((r_state == S_IDLE) || w_bit_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 17'd1;
            end
            if (w_pop) begin
                r_bit_idx <= '0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // Line outputs follow the state one cycle later, giving the two-cycle write-to-start latency.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            r_tx_serial <= 1'b1;
            r_tx_busy   <= 1'b0;
        end else begin
            r_tx_busy <= (r_state != S_IDLE);
            case (r_state)
                S_START: r_tx_serial <= 1'b0;
                S_DATA:  r_tx_serial <= r_shift[0];
                default: r_tx_serial <= 1'b1;
            endcase
        end
    end

endmodule
